uart_rx: RTL



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input with a selectable
// reset level, so an idle-high line does not look active after reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional even parity,
// 1 stop bit. Each bit is sampled at mid-bit using a clock-per-bit counter.
//
// Handshake: valid is a one-cycle strobe with no back-pressure; data_out
// holds the byte from the last good frame until the next one. parity_err
// is only ever high together with valid; frame_err is a lone strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  // Counter values seen on the edge that takes a sample: the start bit is
  // sampled HALF cycles after the falling edge, later bits one full bit on.
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BITS_LAST = 4'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 par_bad, par_bad_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, perr_n, ferr_n;
  logic                 rx_s, rx_prev;
  logic                 at_sample;

  uart_sync #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  // Next-state, datapath and strobe decisions for the frame FSM.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_n     = bit_cnt;
    shift_n   = shift_reg;
    par_bad_n = par_bad;
    data_n    = data_out;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    at_sample = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
    if (at_sample) cnt_n = '0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        // Only a real high-to-low transition starts a frame, so a line that
        // is low coming out of reset is ignored until it first goes high.
        if (!rx_s && rx_prev) begin
          state_n   = START;
          bit_n     = '0;
          par_bad_n = 1'b0;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (at_sample) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (at_sample) begin
          shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == BITS_LAST) begin
            state_n = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_sample) begin
          par_bad_n = rx_s ^ (^shift_reg);
          state_n   = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit lets a back-to-back start edge
        // be caught right where the stop bit ends.
        if (at_sample) begin
          if (rx_s) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
            perr_n  = par_bad && PARITY_EN;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off through a break until the line returns to idle.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      rx_prev    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      shift_reg  <= shift_n;
      par_bad    <= par_bad_n;
      rx_prev    <= rx_s;
      data_out   <= data_n;
      valid      <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

endmodule
